// File: rtl/sprite_pkg.sv
// Shared sprite-sheet constants, per-sprite base offsets and the ROM response tag.
package sprite_pkg;

    localparam int SHEET_W   = 353;
    localparam int ROM_DEPTH = 11296;
    localparam int AW        = 14;
    localparam int XW        = 9;
    localparam int YW        = 6;
    localparam int SW        = AW + 2;

    localparam int PEASHOOTER_BASE = 50;
    localparam int ZOMBIE_BASE     = 2874;
    localparam int PEA_BASE        = 7110;
    localparam int SUN_BASE        = 9300;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rom_tag_t;

    // Kept two bits wider than AW so an overflowing sum is still caught by the range compare.
    function automatic logic [SW-1:0] sheet_sum(input logic [AW-1:0] base,
                                                input logic [XW-1:0] x,
                                                input logic [YW-1:0] y);
        return SW'(base) + SW'(y) * SW'(SHEET_W) + SW'(x);
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant, ROM and response signals between the sprite renderers and the ROM arbiter.
interface sprite_rom_arbiter_if
    import sprite_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] req_base_i;
    logic [N*XW-1:0] req_x_i;
    logic [N*YW-1:0] req_y_i;
    logic [N-1:0]    gnt_o;
    logic            rom_en_o;
    logic [AW-1:0]   rom_addr_o;
    logic [3:0]      rom_q_i;
    logic [N-1:0]    rsp_valid_o;
    logic [3:0]      rsp_data_o;
    logic            addr_err_o;

    modport slave (
        input  req_i, req_base_i, req_x_i, req_y_i, rom_q_i,
        output gnt_o, rom_en_o, rom_addr_o, rsp_valid_o, rsp_data_o, addr_err_o
    );

    modport master (
        output req_i, req_base_i, req_x_i, req_y_i, rom_q_i,
        input  gnt_o, rom_en_o, rom_addr_o, rsp_valid_o, rsp_data_o, addr_err_o
    );
endinterface

// File: rtl/sprite_rom_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx
);
    logic          w_found;
    logic [PW:0]   w_pos;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_pos >= (PW+1)'(N)) begin
                w_pos = w_pos - (PW+1)'(N);
            end
            if (!w_found && i_req[w_pos[PW-1:0]]) begin
                o_gnt[w_pos[PW-1:0]] = 1'b1;
                o_idx                = w_pos[PW-1:0];
                w_found              = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite-sheet ROM among N renderers; grant same cycle,
// response ROM_LAT+1 cycles after accept, fully pipelined in accept order.
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int N       = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                 vga_clk,
    input  logic                 reset,
    sprite_rom_arbiter_if.slave  bus
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] r_rr_ptr;
    logic          r_rom_en;
    logic [AW-1:0] r_rom_addr;
    logic          r_addr_err;
    logic [2:0]    r_acc_idx;
    rom_tag_t      r_tag [ROM_LAT];

    logic [N-1:0]  w_gnt;
    logic [PW-1:0] w_idx;
    logic          w_acc;
    logic [AW-1:0] w_base;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [SW-1:0] w_sum;
    logic          w_oor;
    logic [PW-1:0] w_ptr_nxt;
    rom_tag_t      w_tail;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .i_req (bus.req_i),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign bus.gnt_o = reset ? '0 : w_gnt;
    assign w_acc     = |(bus.req_i & bus.gnt_o);

    assign w_base    = bus.req_base_i[w_idx*AW +: AW];
    assign w_x       = bus.req_x_i[w_idx*XW +: XW];
    assign w_y       = bus.req_y_i[w_idx*YW +: YW];
    assign w_sum     = sheet_sum(w_base, w_x, w_y);
    assign w_oor     = (w_sum >= SW'(ROM_DEPTH));
    assign w_ptr_nxt = (w_idx == PW'(N-1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_addr_err <= 1'b0;
            r_acc_idx  <= '0;
        end else begin
            r_rom_en <= w_acc;
            if (w_acc) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_acc_idx  <= 3'(w_idx);
                r_rom_addr <= w_oor ? '0 : w_sum[AW-1:0];
                if (w_oor) begin
                    r_addr_err <= 1'b1;
                end
            end
        end
    end

    // The tag follows the ROM read, so its tail lines up with rom_q_i.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < ROM_LAT; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= {r_rom_en, r_acc_idx};
            for (int k = 1; k < ROM_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    assign w_tail          = r_tag[ROM_LAT-1];
    assign bus.rsp_valid_o = w_tail.valid ? (N'(1) << w_tail.idx) : '0;
    assign bus.rsp_data_o  = bus.rom_q_i;
    assign bus.rom_en_o    = r_rom_en;
    assign bus.rom_addr_o  = r_rom_addr;
    assign bus.addr_err_o  = r_addr_err;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Table-driven grant checks plus a scoreboard for ROM address and response timing/routing.
module tb_sprite_rom_arbiter;
    import sprite_pkg::*;

    localparam int N = 4;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [3:0] rom_q   = '0;

    always #5 vga_clk = ~vga_clk;

    sprite_rom_arbiter_if #(.N(N)) bus ();

    sprite_rom_arbiter #(.N(N), .ROM_LAT(1)) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    // Behavioural ROM: one-cycle read returning the low address nibble.
    always @(posedge vga_clk) if (bus.rom_en_o) rom_q <= bus.rom_addr_o[3:0];
    assign bus.rom_q_i = rom_q;

    typedef struct {int due; logic [AW-1:0] addr; logic oor;} addr_exp_t;
    typedef struct {int due; logic [3:0] vld; logic [3:0] dat;} rsp_exp_t;
    typedef struct {logic [3:0] req; int base; int x; int y; logic [3:0] gnt;} vec_t;

    addr_exp_t aq[$];
    rsp_exp_t  rq[$];
    vec_t      vt[14];
    int        checks  = 0;
    int        errors  = 0;
    int        cyc     = 0;
    logic      exp_err = 1'b0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge vga_clk) begin
        addr_exp_t ea;
        rsp_exp_t  er;
        if (!reset) begin
            if (aq.size() > 0 && aq[0].due == cyc) begin
                ea = aq.pop_front();
                chk("rom_en", 32'(bus.rom_en_o), 32'd1);
                chk("rom_addr", 32'(bus.rom_addr_o), 32'(ea.addr));
                exp_err = exp_err | ea.oor;
            end else begin
                chk("rom_en_idle", 32'(bus.rom_en_o), 32'd0);
            end
            chk("addr_err", 32'(bus.addr_err_o), 32'(exp_err));
            if (rq.size() > 0 && rq[0].due == cyc) begin
                er = rq.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(er.vld));
                chk("rsp_data", 32'(bus.rsp_data_o), 32'(er.dat));
            end else begin
                chk("rsp_idle", 32'(bus.rsp_valid_o), 32'd0);
            end
        end
    end

    task automatic drive(input logic [3:0] req, input int base, input int x, input int y);
        bus.req_i = req;
        for (int i = 0; i < N; i++) begin
            bus.req_base_i[i*AW +: AW] = AW'(base + i);
            bus.req_x_i[i*XW +: XW]    = XW'(x);
            bus.req_y_i[i*YW +: YW]    = YW'(y);
        end
    endtask

    // Drive one cycle, check the grant, and book the expected address and response.
    task automatic apply(input string name, input logic [3:0] req, input int base,
                         input int x, input int y, input logic [3:0] exp_gnt);
        int   k;
        int   sum;
        logic oor;
        logic [AW-1:0] a;
        drive(req, base, x, y);
        @(negedge vga_clk);
        chk(name, 32'(bus.gnt_o), 32'(exp_gnt));
        if (exp_gnt != 4'b0000) begin
            k = 0;
            for (int i = 0; i < N; i++) if (exp_gnt[i]) k = i;
            sum = base + k + y * SHEET_W + x;
            oor = (sum >= ROM_DEPTH);
            a   = oor ? '0 : AW'(sum);
            aq.push_back('{due: cyc + 1, addr: a, oor: oor});
            rq.push_back('{due: cyc + 2, vld: exp_gnt, dat: a[3:0]});
        end
        @(posedge vga_clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{4'b0001, PEASHOOTER_BASE, 3, 2, 4'b0001};
        vt[1]  = '{4'b0000, 0,              0, 0, 4'b0000};
        vt[2]  = '{4'b1000, ZOMBIE_BASE,    5, 1, 4'b1000};
        vt[3]  = '{4'b1111, PEA_BASE,       0, 0, 4'b0001};
        vt[4]  = '{4'b1111, PEA_BASE,       1, 0, 4'b0010};
        vt[5]  = '{4'b1111, PEA_BASE,       2, 3, 4'b0100};
        vt[6]  = '{4'b1111, PEA_BASE,       3, 4, 4'b1000};
        vt[7]  = '{4'b1111, SUN_BASE,       7, 1, 4'b0001};
        vt[8]  = '{4'b0010, 100,            0, 0, 4'b0010};
        vt[9]  = '{4'b0011, 200,            9, 9, 4'b0001};
        vt[10] = '{4'b0011, 200,            9, 9, 4'b0010};
        vt[11] = '{4'b0001, 300,           11, 1, 4'b0001};
        vt[12] = '{4'b0100, 400,           13, 2, 4'b0100};
        vt[13] = '{4'b0000, 0,              0, 0, 4'b0000};

        drive(4'b1111, 0, 0, 0);
        #1;
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_rom_en", 32'(bus.rom_en_o), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("rst_addr_err", 32'(bus.addr_err_o), 32'd0);
        @(posedge vga_clk);
        #3;
        reset = 1'b0;
        drive(4'b0000, 0, 0, 0);
        @(posedge vga_clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("gnt_vec%0d", i), vt[i].req, vt[i].base, vt[i].x, vt[i].y, vt[i].gnt);
        end

        // Last legal word, first illegal word, then a clearly overflowing address.
        apply("gnt_edge_ok",  4'b0001, 11280, 15, 0, 4'b0001);
        apply("gnt_edge_oor", 4'b0010, 11280, 15, 0, 4'b0010);
        apply("gnt_oor",      4'b0100, 11288, 10, 0, 4'b0100);
        for (int i = 0; i < 3; i++) apply("gnt_idle", 4'b0000, 0, 0, 0, 4'b0000);

        // Reset while an accepted read is still in flight.
        apply("gnt_pre_rst", 4'b0100, 500, 1, 1, 4'b0100);
        #2;
        reset = 1'b1;
        aq.delete();
        rq.delete();
        exp_err = 1'b0;
        drive(4'b1111, 0, 0, 0);
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("mid_rst_rom_en", 32'(bus.rom_en_o), 32'd0);
        chk("mid_rst_rom_addr", 32'(bus.rom_addr_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("mid_rst_addr_err", 32'(bus.addr_err_o), 32'd0);
        @(posedge vga_clk);
        @(negedge vga_clk);
        #2;
        reset = 1'b0;
        drive(4'b0000, 0, 0, 0);
        @(posedge vga_clk);
        #1;
        for (int i = 0; i < 3; i++) apply("gnt_post_idle", 4'b0000, 0, 0, 0, 4'b0000);
        apply("gnt_post_rst", 4'b1111, 60, 2, 2, 4'b0001);
        for (int i = 0; i < 3; i++) apply("gnt_drain", 4'b0000, 0, 0, 0, 4'b0000);

        for (int i = 0; i < 10 && (aq.size() + rq.size()) > 0; i++) @(posedge vga_clk);
        chk("scoreboard_empty", 32'(aq.size() + rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous-read sprite-sheet ROM (palette-indexed, 4-bit pixels) among N sprite renderers (peashooter, zombie, pea, sun, ...).
- Each renderer requests one pixel by sprite base offset and local (x,y).
- The block picks one requester per cycle with round-robin arbitration, forms the linear sheet address, drives the ROM, and routes the returned index to the winning requester with a valid pulse.
- Sits between the per-sprite draw logic and the single ROM/palette pair in the VGA pixel path.

Parameters:
- N, 4, number of requesters (2..8).
- SHEET_W, 353, sprite-sheet row pitch in pixels.
- ROM_DEPTH, 11296, number of ROM words. Addresses >= ROM_DEPTH are illegal.
- AW, 14, ROM address width.
- XW, 9, local x coordinate width.
- YW, 6, local y coordinate width.
- ROM_LAT, 1, ROM read latency in cycles from address to data (1..4).

Ports:
- vga_clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_i  in  N  per-requester request; held until granted.
- req_base_i  in  N*AW  per-requester sprite base offset in the sheet (slot i at bits [i*AW +: AW]).
- req_x_i  in  N*XW  per-requester local x.
- req_y_i  in  N*YW  per-requester local y.
- gnt_o  out  N  one-hot grant, combinational, same cycle as req.
- rom_en_o  out  1  ROM read enable.
- rom_addr_o  out  AW  ROM address.
- rom_q_i  in  4  ROM data.
- rsp_valid_o  out  N  one-hot pulse: rsp_data_o belongs to requester i.
- rsp_data_o  out  4  palette index, shared by all requesters.
- addr_err_o  out  1  sticky: an out-of-range address occurred.

Behaviour:
- Reset (asynchronous):
  - rr_ptr = 0, rom_en_o = 0, rom_addr_o = 0.
  - Tag pipeline cleared, rsp_valid_o = 0, addr_err_o = 0.
  - gnt_o = 0 while reset is high.
- Arbitration (combinational):
  - Search req_i starting at index rr_ptr, wrapping modulo N.
  - The first set bit wins; gnt_o is that one-hot.
  - If req_i == 0, gnt_o = 0.
- Accept: a request is accepted in a cycle where req_i[k] & gnt_o[k]. At most one accept per cycle.
- Pointer update: on accept of k, rr_ptr <= (k+1) mod N. With no accept, rr_ptr holds.
- Address stage (registered at the accept edge):
  - sum = base + y*SHEET_W + x, computed at AW+2 bits, no truncation before the compare.
  - If sum < ROM_DEPTH: rom_addr_o <= sum[AW-1:0].
  - Otherwise: rom_addr_o <= 0 and addr_err_o <= 1. The error stays set until reset.
  - rom_en_o <= 1 on accept, else 0. rom_addr_o holds its last value when idle.
- Tag pipeline: an ROM_LAT-deep shift register of {valid, idx}, loaded with the accept tag one cycle after accept.
- Response: rsp_valid_o[idx] = tail valid; rsp_data_o = rom_q_i (combinational pass-through).
  - Accept in cycle T → response in cycle T+1+ROM_LAT.
  - Fully pipelined: one response per cycle, in accept order.
- Out-of-range requests still produce a response, carrying ROM word 0.
- Requester stability: base, x and y must be stable in the accept cycle only. A requester drops or changes req after being granted.
- Simultaneous events: new accepts and responses in the same cycle are independent.
- Reset mid-flight: pending responses are discarded; no rsp_valid_o pulses appear after reset deasserts until new accepts mature.

Decomposition:
- Shared package sprite_pkg:
  - SHEET_W, ROM_DEPTH, AW, XW, YW constants.
  - Per-sprite base offsets (PEASHOOTER_BASE = 50, etc.).
  - Packed struct rom_tag_t {logic valid; logic [2:0] idx;}.
- Sub-module rr_arbiter:
  - Parameter N; inputs req and ptr; outputs one-hot gnt and the binary index.
  - Purely combinational, reusable elsewhere.

Test Plan (N=4, ROM_LAT=1, behavioural ROM returning addr[3:0]):
- Single request: req_i=0001, base=50, x=3, y=2 → gnt_o=0001 same cycle; rom_addr_o=759 next cycle; rsp_valid_o=0001 with rsp_data_o=7 two cycles after accept.
- Round-robin: req_i=1111 held four cycles → grants 0001, 0010, 0100, 1000 in order; rr_ptr wraps to 0; the fifth grant is 0001.
- Fairness skip: rr_ptr=2, req_i=0011 → gnt_o=0001, then rr_ptr=1.
- Back-to-back: requesters 0 then 2 accepted on consecutive cycles → rsp_valid_o=0001 then 0100 on consecutive cycles, each with matching data.
- Out-of-range: base=11290, x=10, y=0 → rom_addr_o=0, addr_err_o=1 and sticky, response still delivered to the requester.
- Async reset: assert reset one cycle after an accept, mid-edge → outputs clear immediately, no rsp_valid_o pulse after release, first post-reset grant starts at index 0.
